// File: rtl/arb_pkg.sv
// arb_pkg: shared FSM state type, sizing helper and timing constants for the round-robin lock arbiter
package arb_pkg;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
  localparam int DEAD_CYCLES = 1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) if ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/rr_lock_arbiter_if.sv
// rr_lock_arbiter_if: request/grant bundle between requesting masters and the arbiter
interface rr_lock_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_valid;
  logic [ID_W-1:0]    gnt_id;
  logic               hold_expire;
  modport master (output req, input gnt, gnt_valid, gnt_id, hold_expire);
  modport slave  (input req, output gnt, gnt_valid, gnt_id, hold_expire);
endinterface

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational rotate-and-pick, first set request after last_ptr (mod NUM_REQ)
module rr_priority_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_last_ptr,
  output logic               o_any,
  output logic [ID_W-1:0]    o_winner
);
  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  assign w_dbl = {i_req, i_req};
  // bit i of w_rot is requester (last_ptr + 1 + i) mod NUM_REQ
  assign w_rot = NUM_REQ'(w_dbl >> (int'(i_last_ptr) + 1));
  assign o_any = |i_req;
  always_comb begin
    o_winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (w_rot[i]) o_winner = ID_W'((int'(i_last_ptr) + 1 + i) % NUM_REQ);
  end
endmodule

// File: rtl/rr_lock_arbiter.sv
// rr_lock_arbiter: round-robin arbiter that locks the grant to its owner, bounded by a hold counter
module rr_lock_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 16,
  parameter int ID_W     = 2,
  parameter int CNT_W    = 5
) (
  input logic             clk,
  input logic             nreset,
  rr_lock_arbiter_if.slave bus
);
  if (ID_W < clog2(NUM_REQ)) begin : g_bad_id_w
    $error("ID_W too narrow for NUM_REQ");
  end
  if (CNT_W < clog2(MAX_HOLD + 1)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for MAX_HOLD");
  end
  state_t             r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic               r_gnt_valid;
  logic [ID_W-1:0]    r_gnt_id;
  logic [ID_W-1:0]    r_last_ptr;
  logic [CNT_W-1:0]   r_hold_cnt;
  logic               r_hold_expire;
  logic               w_any;
  logic [ID_W-1:0]    w_winner;
  logic               w_owner_req;
  logic               w_expire;
  rr_priority_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .i_req      (bus.req),
    .i_last_ptr (r_last_ptr),
    .o_any      (w_any),
    .o_winner   (w_winner)
  );
  assign w_owner_req = bus.req[r_gnt_id];
  assign w_expire    = (MAX_HOLD != 0) && (r_hold_cnt == CNT_W'(MAX_HOLD));
  // every tenure returns through IDLE, which yields the dead cycle before the next grant
  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_state       <= IDLE;
      r_gnt         <= '0;
      r_gnt_valid   <= 1'b0;
      r_gnt_id      <= '0;
      r_last_ptr    <= ID_W'(NUM_REQ - 1);
      r_hold_cnt    <= '0;
      r_hold_expire <= 1'b0;
    end else begin
      r_hold_expire <= 1'b0;
      if (r_state == IDLE) begin
        if (w_any) begin
          r_gnt       <= NUM_REQ'(1) << w_winner;
          r_gnt_valid <= 1'b1;
          r_gnt_id    <= w_winner;
          r_last_ptr  <= w_winner;
          r_hold_cnt  <= CNT_W'(1);
          r_state     <= GRANT;
        end
      end else if (!w_owner_req || w_expire) begin
        r_gnt         <= '0;
        r_gnt_valid   <= 1'b0;
        r_hold_cnt    <= '0;
        r_hold_expire <= w_owner_req;
        r_state       <= IDLE;
      end else if (r_hold_cnt != '1) begin
        r_hold_cnt <= r_hold_cnt + CNT_W'(1);
      end
    end
  end
  assign bus.gnt         = r_gnt;
  assign bus.gnt_valid   = r_gnt_valid;
  assign bus.gnt_id      = r_gnt_id;
  assign bus.hold_expire = r_hold_expire;
endmodule

// File: tb/tb_rr_lock_arbiter.sv
// tb_rr_lock_arbiter: directed vector table, random run against a reference model, unlimited-hold run
module tb_rr_lock_arbiter;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  rr_lock_arbiter_if #(.NUM_REQ(4), .ID_W(2)) ifa ();
  rr_lock_arbiter_if #(.NUM_REQ(4), .ID_W(2)) ifb ();
  rr_lock_arbiter #(.NUM_REQ(4), .MAX_HOLD(4), .ID_W(2), .CNT_W(5)) u_dut (
    .clk(clk), .nreset(nreset), .bus(ifa)
  );
  rr_lock_arbiter #(.NUM_REQ(4), .MAX_HOLD(0), .ID_W(2), .CNT_W(5)) u_dut0 (
    .clk(clk), .nreset(nreset), .bus(ifb)
  );
  typedef struct {
    logic       nrst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       exp;
  } vec_t;
  vec_t vecs[$];
  task automatic add(input logic n, input logic [3:0] r, input logic [3:0] g, input logic [1:0] i, input logic e);
    vec_t v;
    v.nrst = n; v.req = r; v.gnt = g; v.id = i; v.exp = e;
    vecs.push_back(v);
  endtask
  task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
    end
  endtask
  task automatic drive(input logic n, input logic [3:0] ra, input logic [3:0] rb);
    @(negedge clk);
    nreset = n;
    ifa.req = ra;
    ifb.req = rb;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_a(input string tag, input int step, input logic [3:0] g, input logic [1:0] i, input logic e);
    chk({tag, ".gnt"}, step, 32'(ifa.gnt), 32'(g));
    chk({tag, ".gnt_valid"}, step, 32'(ifa.gnt_valid), 32'(g != 4'b0));
    chk({tag, ".gnt_id"}, step, 32'(ifa.gnt_id), 32'(i));
    chk({tag, ".hold_expire"}, step, 32'(ifa.hold_expire), 32'(e));
  endtask
  // reference model: owner index (-1 = none), tenure length, round-robin history
  int m_owner, m_last, m_ten;
  logic [1:0] m_id;
  logic m_exp;
  task automatic m_step(input logic n, input logic [3:0] r);
    if (!n) begin
      m_owner = -1; m_last = 3; m_id = 2'd0; m_ten = 0; m_exp = 1'b0;
    end else begin
      m_exp = 1'b0;
      if (m_owner < 0) begin
        for (int k = 1; k <= 4; k++)
          if (m_owner < 0 && r[(m_last + k) % 4]) m_owner = (m_last + k) % 4;
        if (m_owner >= 0) begin
          m_last = m_owner; m_id = 2'(m_owner); m_ten = 1;
        end
      end else if (!r[m_owner]) begin
        m_owner = -1;
      end else if (m_ten == 4) begin
        m_owner = -1; m_exp = 1'b1;
      end else begin
        m_ten++;
      end
    end
  endtask
  initial begin
    logic [3:0] rq;
    logic nr;
    ifa.req = '0;
    ifb.req = '0;
    // all request: rotating 4-cycle tenures separated by expiry dead cycles
    add(0, 4'b1111, 4'b0000, 2'd0, 0);
    for (int w = 0; w < 4; w++) begin
      for (int c = 0; c < 4; c++) add(1, 4'b1111, 4'(1 << w), 2'(w), 0);
      add(1, 4'b1111, 4'b0000, 2'(w), 1);
    end
    add(1, 4'b1111, 4'b0001, 2'd0, 0);
    // short tenure released by owner
    add(0, 4'b0000, 4'b0000, 2'd0, 0);
    add(1, 4'b0100, 4'b0100, 2'd2, 0);
    add(1, 4'b0100, 4'b0100, 2'd2, 0);
    add(1, 4'b0000, 4'b0000, 2'd2, 0);
    add(1, 4'b0000, 4'b0000, 2'd2, 0);
    // no pre-emption by a late requester
    add(0, 4'b0000, 4'b0000, 2'd0, 0);
    add(1, 4'b0010, 4'b0010, 2'd1, 0);
    add(1, 4'b1010, 4'b0010, 2'd1, 0);
    add(1, 4'b1000, 4'b0000, 2'd1, 0);
    add(1, 4'b1000, 4'b1000, 2'd3, 0);
    // lone requester: 4 grant + 1 dead, repeating
    add(0, 4'b0000, 4'b0000, 2'd0, 0);
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 4; c++) add(1, 4'b0001, 4'b0001, 2'd0, 0);
      add(1, 4'b0001, 4'b0000, 2'd0, 1);
    end
    // owner re-request in dead cycle loses to another requester
    add(0, 4'b0000, 4'b0000, 2'd0, 0);
    for (int c = 0; c < 4; c++) add(1, 4'b0011, 4'b0001, 2'd0, 0);
    add(1, 4'b0011, 4'b0000, 2'd0, 1);
    add(1, 4'b0011, 4'b0010, 2'd1, 0);
    // reset mid-grant clears pointer history
    add(0, 4'b0000, 4'b0000, 2'd0, 0);
    add(1, 4'b0100, 4'b0100, 2'd2, 0);
    add(1, 4'b0110, 4'b0100, 2'd2, 0);
    add(0, 4'b0110, 4'b0000, 2'd0, 0);
    add(1, 4'b0110, 4'b0010, 2'd1, 0);
    foreach (vecs[i]) begin
      drive(vecs[i].nrst, vecs[i].req, 4'b0000);
      chk_a("vec", i, vecs[i].gnt, vecs[i].id, vecs[i].exp);
    end
    // random traffic against the reference model
    rq = 4'b0000;
    drive(1'b0, rq, 4'b0000);
    m_step(1'b0, rq);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
      nr = ($urandom_range(0, 63) != 0);
      drive(nr, rq, 4'b0000);
      m_step(nr, rq);
      chk_a("rnd", i, (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner), m_id, m_exp);
    end
    // unlimited hold: grant never expires
    drive(1'b0, 4'b0000, 4'b0000);
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 4'b0000, 4'b0010);
      chk("inf.gnt", i, 32'(ifb.gnt), 32'(4'b0010));
      chk("inf.hold_expire", i, 32'(ifb.hold_expire), 32'd0);
    end
    drive(1'b1, 4'b0000, 4'b0000);
    chk("inf.release", 0, 32'(ifb.gnt), 32'd0);
    chk("inf.id_held", 0, 32'(ifb.gnt_id), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
